// File: rtl/bsg_axil_fifo_channel_arbiter.sv
// Write demux and read round-robin arbiter between an AXI-Lite FIFO bridge and N channels.
// Optional macro BSG_AXIL_CHAN_ARB_TAG_EN: tag response MSBs with the granted channel index.
module bsg_axil_fifo_channel_arbiter #(
    parameter int num_chan_p   = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int chan_lsb_p   = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             fifo_v_i,
    input  logic [addr_width_p-1:0]          fifo_addr_i,
    input  logic [data_width_p-1:0]          fifo_data_i,
    output logic                             fifo_yumi_o,
    output logic [num_chan_p-1:0]            chan_v_o,
    output logic [addr_width_p-1:0]          chan_addr_o,
    output logic [data_width_p-1:0]          chan_data_o,
    input  logic [num_chan_p-1:0]            chan_ready_i,
    input  logic [num_chan_p-1:0]            resp_v_i,
    input  logic [num_chan_p*data_width_p-1:0] resp_data_i,
    output logic [num_chan_p-1:0]            resp_yumi_o,
    output logic                             to_fifo_v_o,
    output logic [data_width_p-1:0]          to_fifo_data_o,
    input  logic                             to_fifo_ready_i,
    output logic [7:0]                       drop_count_o
);

    localparam int chan_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam logic [num_chan_p-1:0] one_lp = {{(num_chan_p-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SEND} state_e;

    state_e                    state_r, state_n;
    logic [addr_width_p-1:0]   addr_r;
    logic [data_width_p-1:0]   data_r;
    logic [num_chan_p-1:0]     onehot_r;
    logic [7:0]                drop_r;
    logic [chan_width_lp-1:0]  sel;
    logic                      in_range;
    logic                      chan_hs;
    logic                      yumi;
    logic                      load;
    logic                      drop;

    assign sel      = fifo_addr_i[chan_lsb_p +: chan_width_lp];
    assign in_range = ({1'b0, sel} < (chan_width_lp+1)'(num_chan_p));
    assign chan_hs  = (state_r == SEND) && |(onehot_r & chan_ready_i);

    // Write FSM: accept from the bridge when idle or when the held write drains.
    always_comb begin
        state_n = state_r;
        yumi    = 1'b0;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state_r)
            IDLE: begin
                if (fifo_v_i) begin
                    yumi = 1'b1;
                    if (in_range) begin
                        load    = 1'b1;
                        state_n = SEND;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            SEND: begin
                if (chan_hs) begin
                    if (fifo_v_i) begin
                        yumi = 1'b1;
                        if (in_range) begin
                            load = 1'b1;
                        end else begin
                            drop    = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fifo_yumi_o = yumi & reset_n_i;
    assign chan_v_o    = (state_r == SEND) ? onehot_r : '0;
    assign chan_addr_o = addr_r;
    assign chan_data_o = data_r;
    assign drop_count_o = drop_r;

    // Write state, one-entry output register and saturating drop counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            addr_r   <= '0;
            data_r   <= '0;
            onehot_r <= '0;
            drop_r   <= '0;
        end else begin
            state_r <= state_n;
            if (load) begin
                addr_r   <= fifo_addr_i;
                data_r   <= fifo_data_i;
                onehot_r <= one_lp << sel;
            end
            if (drop && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    logic [chan_width_lp-1:0]  last_r;
    logic [chan_width_lp-1:0]  grant;
    logic                      found;
    logic                      resp_hs;
    logic [data_width_p-1:0]   grant_data;
    int                        idx;

    // Round-robin grant: first valid channel after the last granted one.
    always_comb begin
        grant = last_r;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= num_chan_p; i++) begin
            idx = int'(last_r) + i;
            if (idx >= num_chan_p) begin
                idx = idx - num_chan_p;
            end
            if (!found && resp_v_i[idx]) begin
                grant = chan_width_lp'(idx);
                found = 1'b1;
            end
        end
    end

    assign resp_hs     = to_fifo_ready_i & found & reset_n_i;
    assign resp_yumi_o = resp_hs ? (one_lp << grant) : '0;
    assign to_fifo_v_o = |resp_v_i;
    assign grant_data  = resp_data_i[int'(grant)*data_width_p +: data_width_p];

`ifdef BSG_AXIL_CHAN_ARB_TAG_EN
    assign to_fifo_data_o = {grant, grant_data[data_width_p-chan_width_lp-1:0]};
`else
    assign to_fifo_data_o = grant_data;
`endif

    // Last-grant pointer moves only on a completed response handshake.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_r <= chan_width_lp'(num_chan_p - 1);
        end else if (resp_hs) begin
            last_r <= grant;
        end
    end

endmodule
